conv_loop_scheduler: RTL and testbench

CONV_LOOP_SCHEDULER -- requirements
Module: conv_loop_scheduler

---
 rtl/conv_loop_scheduler_if.sv | 10 +
 rtl/conv_loop_scheduler.sv | 101 ++++++++++
 tb/tb_conv_loop_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/conv_loop_scheduler_if.sv
// conv_loop_scheduler_if: control handshake and index/write-strobe bundle of the convolution loop scheduler.
interface conv_loop_scheduler_if;
    logic start, advance;
    logic [7:0] m, r, c, n;
    logic [3:0] i, j;
    logic idx_valid, acc_clr, out_wr, busy, done;
    logic [15:0] out_addr;
    modport master (output start, advance, input m, r, c, n, i, j, idx_valid, acc_clr, out_wr, out_addr, busy, done);
    modport slave (input start, advance, output m, r, c, n, i, j, idx_valid, acc_clr, out_wr, out_addr, busy, done);
endinterface

// File: rtl/conv_loop_scheduler.sv
// conv_loop_scheduler: walks the six-deep conv loop nest and strobes output writes once each pixel's accumulator is final.
module conv_loop_scheduler #(
    parameter int K = 5,
    parameter int OUT_SIZE = 28,
    parameter int OUT_CH = 6,
    parameter int IN_GRP = 1,
    parameter int PIPE_LAT = 10
) (
    input logic clock,
    input logic reset,
    conv_loop_scheduler_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state;
    logic [7:0] m, r, c, n;
    logic [3:0] i, j, cnt;
    logic busy, done;
    logic issue, j_last, i_last, n_last, c_last, r_last, m_last, pix_last, fin;
    logic [15:0] pix_addr;
    logic [PIPE_LAT-1:0] vld;
    logic [15:0] addr [PIPE_LAT];
    always_comb begin
        issue = state == RUN && bus.advance;
        j_last = j == 4'(K - 1);
        i_last = i == 4'(K - 1);
        n_last = n == 8'(IN_GRP - 1);
        c_last = c == 8'(OUT_SIZE - 1);
        r_last = r == 8'(OUT_SIZE - 1);
        m_last = m == 8'(OUT_CH - 1);
        pix_last = n_last && i_last && j_last;
        fin = pix_last && c_last && r_last && m_last;
        pix_addr = 16'(m) * 16'(OUT_SIZE * OUT_SIZE) + 16'(r) * 16'(OUT_SIZE) + 16'(c);
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            {m, r, c, n, i, j} <= '0;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    {m, r, c, n, i, j} <= '0;
                    state <= RUN;
                    busy <= 1'b1;
                end
                RUN: if (issue) begin
                    j <= j_last ? '0 : j + 4'd1;
                    if (j_last) i <= i_last ? '0 : i + 4'd1;
                    if (j_last && i_last) n <= n_last ? '0 : n + 8'd1;
                    if (pix_last) c <= c_last ? '0 : c + 8'd1;
                    if (pix_last && c_last) r <= r_last ? '0 : r + 8'd1;
                    if (pix_last && c_last && r_last) m <= m_last ? '0 : m + 8'd1;
                    if (fin) begin
                        state <= DRAIN;
                        cnt <= '0;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'(PIPE_LAT - 1)) begin
                        state <= DONE;
                        busy <= 1'b0;
                        done <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
    // token line runs free of advance so write timing depends only on issue time
    always_ff @(posedge clock) begin
        if (reset) begin
            vld <= '0;
            for (int k = 0; k < PIPE_LAT; k++) addr[k] <= '0;
        end else begin
            vld[0] <= issue && pix_last;
            addr[0] <= pix_addr;
            for (int k = 1; k < PIPE_LAT; k++) begin
                vld[k] <= vld[k-1];
                addr[k] <= addr[k-1];
            end
        end
    end
    assign bus.m = m;
    assign bus.r = r;
    assign bus.c = c;
    assign bus.n = n;
    assign bus.i = i;
    assign bus.j = j;
    assign bus.idx_valid = issue;
    assign bus.acc_clr = issue && n == 8'd0 && i == 4'd0 && j == 4'd0;
    assign bus.out_wr = vld[PIPE_LAT-1];
    assign bus.out_addr = addr[PIPE_LAT-1];
    assign bus.busy = busy;
    assign bus.done = done;
endmodule

// File: tb/tb_conv_loop_scheduler.sv
// tb_conv_loop_scheduler: scoreboard bench; expected indices decoded from a flat issue count, write addresses queued per pixel.
module tb_conv_loop_scheduler;
    localparam int KA = 2, SA = 2, CA = 1, GA = 1, LA = 3, PA = KA * KA * GA;
    localparam int KB = 3, SB = 3, CB = 2, GB = 2, LB = 5, PB = KB * KB * GB;
    logic clock = 1'b0, reset = 1'b1;
    bit mon = 1'b0;
    int cyc = 0, total = 0, bad = 0;
    int qa, na, wa, ca, da, first_a, last_a, done_a;
    int qb, nb, wb, cb, db, last_b, done_b, addr_b;
    int qwa[$], qca[$], qwb[$], qcb[$];
    conv_loop_scheduler_if a();
    conv_loop_scheduler_if b();
    conv_loop_scheduler #(.K(KA), .OUT_SIZE(SA), .OUT_CH(CA), .IN_GRP(GA), .PIPE_LAT(LA))
        dut_a (.clock(clock), .reset(reset), .bus(a));
    conv_loop_scheduler #(.K(KB), .OUT_SIZE(SB), .OUT_CH(CB), .IN_GRP(GB), .PIPE_LAT(LB))
        dut_b (.clock(clock), .reset(reset), .bus(b));
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    always @(negedge clock) if (mon) begin
        int px, kk;
        px = qa / PA;
        kk = qa % PA;
        chk("a_clr", a.acc_clr, (a.idx_valid && kk == 0) ? 1 : 0);
        if (a.idx_valid) begin
            chk("a_j", a.j, kk % KA);
            chk("a_i", a.i, (kk / KA) % KA);
            chk("a_n", a.n, kk / (KA * KA));
            chk("a_c", a.c, px % SA);
            chk("a_r", a.r, (px / SA) % SA);
            chk("a_m", a.m, px / (SA * SA));
            if (kk == PA - 1) begin
                qwa.push_back(px);
                qca.push_back(cyc + LA);
            end
            if (na == 0) first_a = cyc;
            last_a = cyc;
            na++;
            qa++;
        end
        if (a.out_wr) begin
            if (qwa.size() == 0) chk("a_wr_extra", 1, 0);
            else begin
                chk("a_addr", a.out_addr, qwa.pop_front());
                chk("a_wr_cyc", cyc, qca.pop_front());
            end
            wa++;
        end
        if (a.acc_clr) ca++;
        if (a.done) begin
            da++;
            done_a = cyc;
        end
    end
    always @(negedge clock) if (mon) begin
        int px, kk;
        px = qb / PB;
        kk = qb % PB;
        chk("b_clr", b.acc_clr, (b.idx_valid && kk == 0) ? 1 : 0);
        if (b.idx_valid) begin
            chk("b_j", b.j, kk % KB);
            chk("b_i", b.i, (kk / KB) % KB);
            chk("b_n", b.n, kk / (KB * KB));
            chk("b_c", b.c, px % SB);
            chk("b_r", b.r, (px / SB) % SB);
            chk("b_m", b.m, px / (SB * SB));
            if (kk == PB - 1) begin
                qwb.push_back(px);
                qcb.push_back(cyc + LB);
            end
            last_b = cyc;
            nb++;
            qb++;
        end
        if (b.out_wr) begin
            if (qwb.size() == 0) chk("b_wr_extra", 1, 0);
            else begin
                chk("b_addr", b.out_addr, qwb.pop_front());
                chk("b_wr_cyc", cyc, qcb.pop_front());
            end
            addr_b = b.out_addr;
            wb++;
        end
        if (b.acc_clr) cb++;
        if (b.done) begin
            db++;
            done_b = cyc;
        end
    end
    task automatic run_a(input int mode, input bit stray);
        qa = 0; na = 0; wa = 0; ca = 0; da = 0;
        a.start = 1'b1;
        a.advance = mode == 1 ? 1'b0 : 1'b1;
        tick;
        a.start = 1'b0;
        for (int k = 0; k < 400 && da == 0; k++) begin
            a.advance = mode == 1 ? !a.advance : 1'b1;
            a.start = stray && a.busy && k % 3 == 0;
            tick;
        end
        a.start = 1'b0;
        a.advance = 1'b1;
        repeat (LA + 6) tick;
        chk("a_issues", na, CA * SA * SA * PA);
        chk("a_wrs", wa, CA * SA * SA);
        chk("a_clrs", ca, CA * SA * SA);
        chk("a_done_cnt", da, 1);
        chk("a_span", last_a - first_a, mode == 1 ? 30 : 15);
        chk("a_done_lat", done_a - last_a, LA + 1);
        chk("a_pending", qwa.size(), 0);
        chk("a_busy_end", a.busy, 0);
    endtask
    initial begin
        a.start = 1'b0; a.advance = 1'b0; b.start = 1'b0; b.advance = 1'b0;
        repeat (3) tick;
        chk("rst_busy", a.busy, 0);
        chk("rst_done", a.done, 0);
        chk("rst_wr", a.out_wr, 0);
        chk("rst_valid", a.idx_valid, 0);
        chk("rst_addr", a.out_addr, 0);
        chk("rst_idx", a.m + a.r + a.c + a.n + a.i + a.j, 0);
        reset = 1'b0;
        mon = 1'b1;
        repeat (2) tick;
        run_a(0, 1'b0);
        run_a(1, 1'b0);
        run_a(0, 1'b1);
        qa = 0; na = 0;
        a.start = 1'b1; a.advance = 1'b1;
        tick;
        a.start = 1'b0;
        for (int k = 0; k < 50 && na < 9; k++) tick;
        reset = 1'b1;
        a.start = 1'b1;
        tick;
        reset = 1'b0;
        a.start = 1'b0;
        chk("mid_rst_issue", na, 10);
        chk("mid_rst_busy", a.busy, 0);
        chk("mid_rst_idx", a.m + a.r + a.c + a.n + a.i + a.j, 0);
        qwa.delete();
        qca.delete();
        wa = 0;
        repeat (12) tick;
        chk("mid_rst_no_wr", wa, 0);
        chk("mid_rst_idle", a.busy, 0);
        run_a(0, 1'b0);
        qb = 0; nb = 0; wb = 0; cb = 0; db = 0;
        b.start = 1'b1; b.advance = 1'b1;
        tick;
        b.start = 1'b0;
        for (int k = 0; k < 3000 && db == 0; k++) begin
            b.advance = $urandom_range(0, 3) != 0;
            tick;
        end
        repeat (LB + 6) tick;
        chk("b_issues", nb, CB * SB * SB * PB);
        chk("b_wrs", wb, CB * SB * SB);
        chk("b_clrs", cb, CB * SB * SB);
        chk("b_done_cnt", db, 1);
        chk("b_last_addr", addr_b, CB * SB * SB - 1);
        chk("b_done_lat", done_b - last_b, LB + 1);
        chk("b_pending", qwb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end
endmodule
